// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with dead-time blanking,
// leading-zero blanking and a frame-synchronous load handshake.
module seven_seg_scan #(
  parameter int unsigned CLK_DIV        = 1000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic        lzb_en,
  output logic [3:0]  nibble,
  output logic [3:0]  dig_sel,
  output logic        dp,
  output logic        load_ack,
  output logic        frame_tick
);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] active;
  logic [3:0]  dp_active;
  logic [15:0] pend_val;
  logic [3:0]  pend_dp;
  logic        pend;

  logic        wrap;
  logic        boundary;
  logic [15:0] cnt_nxt;
  logic [3:0]  lz;
  logic        shown;
  logic [3:0]  sel_on;
  logic [3:0]  sel_idle;

  assign sel_idle = DIG_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  always_comb begin
    wrap     = (cnt == 16'(CLK_DIV - 1));
    boundary = wrap && (idx == 2'd3);
    cnt_nxt  = wrap ? '0 : cnt + 16'd1;
    // A digit is blanked only when it and every more significant nibble are zero.
    lz       = '0;
    lz[1]    = lzb_en && (active[15:4] == 12'd0);
    lz[2]    = lzb_en && (active[15:8] == 8'd0);
    lz[3]    = lzb_en && (active[15:12] == 4'd0);
    shown    = digit_en[idx] && !lz[idx];
    sel_on   = '0;
    if (state == DRIVE && shown) sel_on = 4'b0001 << idx;
  end

  // Scan counter, digit index and slot state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= BLANK;
    end else begin
      cnt   <= cnt_nxt;
      if (wrap) idx <= idx + 2'd1;
      state <= ({16'd0, cnt_nxt} < BLANK_CYC) ? BLANK : DRIVE;
    end
  end

  // Load handshake: active data only changes on a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= '0;
      dp_active <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend      <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        active    <= value_in;
        dp_active <= dp_in;
      end else if (pend) begin
        active    <= pend_val;
        dp_active <= pend_dp;
      end
      pend <= 1'b0;
    end else if (load) begin
      pend_val <= value_in;
      pend_dp  <= dp_in;
      pend     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nibble     <= '0;
      dig_sel    <= sel_idle;
      dp         <= 1'b0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      nibble     <= active[4*idx +: 4];
      dig_sel    <= DIG_ACTIVE_LOW ? ~sel_on : sel_on;
      dp         <= (state == DRIVE) && shown && dp_active[idx];
      load_ack   <= boundary && (pend || load);
      frame_tick <= boundary;
    end
  end

endmodule
